// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: NUM_M masters share one slave port.
// Ownership is held for the whole CYC, extended by LOCK; a watchdog forces ERR on hung transfers.
module wishbone_rr_arbiter #(
  parameter int NUM_M     = 4,
  parameter int WB_ADDR_W = 32,
  parameter int WB_DATA_W = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic [NUM_M-1:0]             M_CYC_I,
  input  logic [NUM_M-1:0]             M_STB_I,
  input  logic [NUM_M-1:0]             M_WE_I,
  input  logic [NUM_M-1:0]             M_LOCK_I,
  input  logic [NUM_M*WB_ADDR_W-1:0]   M_ADR_I,
  input  logic [NUM_M*WB_DATA_W-1:0]   M_DAT_I,
  input  logic [NUM_M*WB_DATA_W/8-1:0] M_SEL_I,
  input  logic [NUM_M*3-1:0]           M_CTI_I,
  input  logic [NUM_M*2-1:0]           M_BTE_I,
  output logic [WB_DATA_W-1:0]         M_DAT_O,
  output logic [NUM_M-1:0]             M_ACK_O,
  output logic [NUM_M-1:0]             M_ERR_O,
  output logic [NUM_M-1:0]             M_RTY_O,
  output logic                         S_CYC_O,
  output logic                         S_STB_O,
  output logic                         S_WE_O,
  output logic                         S_LOCK_O,
  output logic [WB_ADDR_W-1:0]         S_ADR_O,
  output logic [WB_DATA_W-1:0]         S_DAT_O,
  output logic [WB_DATA_W/8-1:0]       S_SEL_O,
  output logic [2:0]                   S_CTI_O,
  output logic [1:0]                   S_BTE_O,
  input  logic [WB_DATA_W-1:0]         S_DAT_I,
  input  logic                         S_ACK_I,
  input  logic                         S_ERR_I,
  input  logic                         S_RTY_I,
  output logic [NUM_M-1:0]             GNT_O
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = WB_DATA_W / 8;

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     last, last_n, pick;
  logic [NUM_M-1:0]  gnt, gnt_n;
  logic [9:0]        wdog, wdog_n;
  logic              found;
  int                j;

  logic                 o_cyc, o_stb, o_we, o_lock;
  logic [WB_ADDR_W-1:0] o_adr;
  logic [WB_DATA_W-1:0] o_dat;
  logic [SW-1:0]        o_sel;
  logic [2:0]           o_cti;
  logic [1:0]           o_bte;

  logic own, abrt, term;

  // Owner's bus, selected by the last-owner pointer
  always_comb begin
    o_cyc  = 1'b0;
    o_stb  = 1'b0;
    o_we   = 1'b0;
    o_lock = 1'b0;
    o_adr  = '0;
    o_dat  = '0;
    o_sel  = '0;
    o_cti  = '0;
    o_bte  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (last == IW'(i)) begin
        o_cyc  = M_CYC_I[i];
        o_stb  = M_STB_I[i];
        o_we   = M_WE_I[i];
        o_lock = M_LOCK_I[i];
        o_adr  = M_ADR_I[i*WB_ADDR_W +: WB_ADDR_W];
        o_dat  = M_DAT_I[i*WB_DATA_W +: WB_DATA_W];
        o_sel  = M_SEL_I[i*SW +: SW];
        o_cti  = M_CTI_I[i*3 +: 3];
        o_bte  = M_BTE_I[i*2 +: 2];
      end
    end
  end

  // First requester searching upward from last+1, with wrap
  always_comb begin
    pick  = last;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      j = (int'(last) + k) % NUM_M;
      if (!found && M_CYC_I[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign own  = (state == OWN);
  assign abrt = (state == ABORT);
  assign term = S_ACK_I | S_ERR_I | S_RTY_I;

  assign S_CYC_O  = own & o_cyc;
  assign S_STB_O  = own & o_cyc & o_stb;
  assign S_WE_O   = own & o_we;
  assign S_LOCK_O = own & o_lock;
  assign S_ADR_O  = own ? o_adr : '0;
  assign S_DAT_O  = own ? o_dat : '0;
  assign S_SEL_O  = own ? o_sel : '0;
  assign S_CTI_O  = own ? o_cti : '0;
  assign S_BTE_O  = own ? o_bte : '0;

  assign M_DAT_O = own ? S_DAT_I : '0;
  assign M_ACK_O = {NUM_M{own & S_ACK_I}} & gnt;
  assign M_RTY_O = {NUM_M{own & S_RTY_I}} & gnt;
  assign M_ERR_O = {NUM_M{(own & S_ERR_I) | abrt}} & gnt;
  assign GNT_O   = gnt;

  always_comb begin
    state_n = state;
    last_n  = last;
    gnt_n   = gnt;
    wdog_n  = wdog;
    unique case (state)
      IDLE: begin
        wdog_n = '0;
        if (found) begin
          state_n = OWN;
          last_n  = pick;
          gnt_n   = NUM_M'(1) << pick;
        end
      end
      OWN: begin
        if (!o_cyc && !o_lock) begin
          state_n = IDLE;
          gnt_n   = '0;
          wdog_n  = '0;
        end else if (S_STB_O && !term) begin
          // Termination has priority over the timeout in the same cycle
          if (wdog == 10'(TIMEOUT - 1)) begin
            state_n = ABORT;
            wdog_n  = '0;
          end else begin
            wdog_n = wdog + 10'd1;
          end
        end else begin
          wdog_n = '0;
        end
      end
      ABORT: begin
        state_n = OWN;
        wdog_n  = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        wdog_n  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= IDLE;
      last  <= IW'(NUM_M - 1);
      gnt   <= '0;
      wdog  <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      gnt   <= gnt_n;
      wdog  <= wdog_n;
    end
  end

endmodule

// File: doc/wishbone_rr_arbiter.md
Name: wishbone_rr_arbiter

Overview:
- Shares one Wishbone B4 slave port between NUM_M Wishbone masters, e.g. several traffic-generator masters driving one memory model.
- Uses registered round-robin arbitration with ownership held for the whole CYC, extended by LOCK.
- A per-transfer watchdog terminates hung transfers with ERR.
- Sits between the master instances and the single slave under test.

Parameters:
- NUM_M, 4, number of masters (2..8).
- WB_ADDR_W, 32, address width.
- WB_DATA_W, 32, data width; SEL width is WB_DATA_W/8.
- TIMEOUT, 255, cycles a strobed transfer may wait for ACK/ERR/RTY before forced ERR (1..1023).

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  asynchronous, active-low reset.
- M_CYC_I  in  NUM_M  per-master CYC; bit i belongs to master i.
- M_STB_I  in  NUM_M  per-master STB.
- M_WE_I  in  NUM_M  per-master WE.
- M_LOCK_I  in  NUM_M  per-master LOCK.
- M_ADR_I  in  NUM_M*WB_ADDR_W  packed addresses; master i at [i*WB_ADDR_W +: WB_ADDR_W].
- M_DAT_I  in  NUM_M*WB_DATA_W  packed write data.
- M_SEL_I  in  NUM_M*WB_DATA_W/8  packed byte selects.
- M_CTI_I  in  NUM_M*3  packed CTI.
- M_BTE_I  in  NUM_M*2  packed BTE.
- M_DAT_O  out  WB_DATA_W  read data, broadcast to all masters.
- M_ACK_O  out  NUM_M  per-master ACK.
- M_ERR_O  out  NUM_M  per-master ERR.
- M_RTY_O  out  NUM_M  per-master RTY.
- S_CYC_O, S_STB_O, S_WE_O, S_LOCK_O  out  1 each  slave controls.
- S_ADR_O  out  WB_ADDR_W  slave address.
- S_DAT_O  out  WB_DATA_W  slave write data.
- S_SEL_O  out  WB_DATA_W/8  slave byte selects.
- S_CTI_O  out  3  slave CTI.
- S_BTE_O  out  2  slave BTE.
- S_DAT_I  in  WB_DATA_W  slave read data.
- S_ACK_I, S_ERR_I, S_RTY_I  in  1 each  slave terminations.
- GNT_O  out  NUM_M  one-hot current owner (registered); all zero when idle.

Behaviour:
- Reset (async, RST_I=0): state IDLE, GNT_O=0, last-owner pointer=NUM_M-1, watchdog=0. All S_* outputs and all M_ACK/ERR/RTY_O are 0. M_DAT_O is 0 when idle.
- FSM states: IDLE, OWN, ABORT.
- IDLE:
  - If any M_CYC_I bit is set, pick the first set bit searching upward from (last+1) mod NUM_M, with wrap.
  - Register GNT_O one-hot to that master, set last=owner, go to OWN.
  - Grant latency is exactly 1 cycle from first CYC to GNT_O; no slave signal is asserted in that cycle.
- OWN:
  - S_* outputs are combinationally muxed from the owner's inputs.
  - S_CYC_O = owner CYC, S_STB_O = owner CYC & STB.
  - S_ACK/ERR/RTY_I route to the owner bit only; non-owners see 0.
  - M_DAT_O = S_DAT_I.
- Release: in OWN, when owner M_CYC_I=0 and M_LOCK_I=0, go to IDLE and clear GNT_O.
  - If owner CYC=0 but LOCK=1, stay in OWN and keep the grant; S_CYC_O=0 meanwhile.
  - A released master is not re-granted the next cycle if any other master requests (round-robin fairness).
  - A master always waits ≥1 IDLE cycle between owners.
- Watchdog:
  - Counter increments each cycle in OWN while S_STB_O=1 and no S_ACK/ERR/RTY_I.
  - Clears on any termination or when S_STB_O=0.
  - When count reaches TIMEOUT, go to ABORT.
- ABORT (1 cycle):
  - Drive M_ERR_O[owner]=1 and force S_CYC_O=S_STB_O=0.
  - Clear watchdog and return to OWN; the grant is kept, so the master decides whether to drop CYC.
  - A slave termination arriving in the ABORT cycle is ignored.
- Simultaneous events:
  - Termination in the same cycle the watchdog hits TIMEOUT: termination wins; count clears, no ABORT.
  - New requests during OWN are ignored until release.
  - Owner dropping CYC in the same cycle as ACK: the ACK is still delivered, then release.
- Non-owner masters asserting STB see no termination and must wait. No queueing; requests are sampled level-wise.
- Reset mid-transfer: all outputs drop asynchronously to their reset values; the pointer returns to NUM_M-1, so master 0 has first priority after reset.

Test Plan:
- Single master: M_CYC_I=4'b0100 with STB, slave ACKs 2 cycles later → GNT_O=4'b0100 one cycle after CYC, S_ADR_O=master-2 address, M_ACK_O=4'b0100 exactly once, GNT_O=0 the cycle after CYC drops.
- Contention: all four masters hold CYC, each performs 1 transfer then drops CYC for 1 cycle → grant order 0,1,2,3,0 and no master is granted twice in a row.
- LOCK hold: master 1 does a read with LOCK=1, drops CYC for 3 cycles, then writes, while master 3 requests → GNT_O stays 4'b0010 throughout; master 3 is granted only after master 1 drops both CYC and LOCK.
- Watchdog: TIMEOUT=8, slave never acks master 0 → M_ERR_O[0]=1 on the 9th strobed cycle, S_STB_O=0 that cycle, then GNT_O is still 4'b0001.
- Boundary: ACK arrives in the cycle the watchdog reaches TIMEOUT → M_ACK_O set, no ERR. A burst with CTI=3'b010, BTE=2'b01 passes S_CTI_O/S_BTE_O unchanged.
- Reset mid-burst: RST_I low while master 2 owns → GNT_O and S_CYC_O go to 0 immediately; after release with masters 0 and 3 requesting, master 0 is granted first.
